// File: rtl/regfile_wb_queue.sv
// Write-back queue: merges ALU and load results into the single register
// file write port in program order, with a bypass lookup for decode.

// Per-slot destination compare against both decode read ports; x0 never matches.
module regfile_wb_match (
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hit1,
  output logic       hit2
);
  assign hit1 = (rs1 != 5'd0) && (rd == rs1);
  assign hit2 = (rs2 != 5'd0) && (rd == rs2);
endmodule

module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_valid,
  input  logic [4:0]                   mem_rd,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         alu_valid,
  input  logic [4:0]                   alu_rd,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         in_ready,
  output logic                         wb_en,
  output logic [4:0]                   wb_rd,
  output logic [DATA_W-1:0]            wb_data,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  output logic                         rs1_hit,
  output logic                         rs2_hit,
  output logic [DATA_W-1:0]            rs1_data,
  output logic [DATA_W-1:0]            rs2_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  wb_ent_t [DEPTH-1:0] q;
  logic [PW-1:0]       head, tail;
  logic [DEPTH-1:0]    m1, m2;
  logic                wm1, wm2;

  // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [PW:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + n;
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  logic          mem_req, alu_req, mem_acc, alu_acc, pop;
  logic [PW:0]   push_cnt;
  logic [PW-1:0] alu_slot;

  // Readiness is conservative (ignores the same-cycle pop) so two pushes always fit.
  assign in_ready = (count <= CW'(DEPTH-2));
  assign mem_req  = mem_valid && (mem_rd != 5'd0);
  assign alu_req  = alu_valid && (alu_rd != 5'd0);
  assign mem_acc  = mem_req && in_ready;
  assign alu_acc  = alu_req && in_ready;
  assign pop      = (count != '0);
  assign push_cnt = (PW+1)'(mem_acc) + (PW+1)'(alu_acc);
  assign alu_slot = mem_acc ? wrap_add(tail, (PW+1)'(1)) : tail;

  // Entry storage: mem lands at tail, alu behind it when both arrive together.
  always_ff @(posedge clk) begin
    if (mem_acc) q[tail]     <= '{rd: mem_rd, data: mem_data};
    if (alu_acc) q[alu_slot] <= '{rd: alu_rd, data: alu_data};
  end

  // Pointers, occupancy, sticky overflow and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      tail  <= wrap_add(tail, push_cnt);
      count <= count + CW'(push_cnt) - CW'(pop);
      if ((mem_req || alu_req) && !in_ready) overflow <= 1'b1;
      if (pop) begin
        wb_en   <= 1'b1;
        wb_rd   <= q[head].rd;
        wb_data <= q[head].data;
        head    <= wrap_add(head, (PW+1)'(1));
      end else begin
        wb_en <= 1'b0;
      end
    end
  end

  genvar s;
  generate
    for (s = 0; s < DEPTH; s++) begin : g_match
      regfile_wb_match u_match (
        .rd  (q[s].rd),
        .rs1 (rs1),
        .rs2 (rs2),
        .hit1(m1[s]),
        .hit2(m2[s])
      );
    end
  endgenerate

  regfile_wb_match u_wb_match (
    .rd  (wb_rd),
    .rs1 (rs1),
    .rs2 (rs2),
    .hit1(wm1),
    .hit2(wm2)
  );

  // Bypass: start from the wb register, then walk oldest->youngest so the
  // youngest occupied match overrides anything older.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    rs1_hit  = wb_en && wm1;
    rs2_hit  = wb_en && wm2;
    rs1_data = (wb_en && wm1) ? wb_data : '0;
    rs2_data = (wb_en && wm2) ? wb_data : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = wrap_add(head, (PW+1)'(i));
      if (CW'(i) < count) begin
        if (m1[idx]) begin
          rs1_hit  = 1'b1;
          rs1_data = q[idx].data;
        end
        if (m2[idx]) begin
          rs2_hit  = 1'b1;
          rs2_data = q[idx].data;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed table-driven bench for regfile_wb_queue (DEPTH=4, DATA_W=32).
module tb_regfile_wb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_rd, alu_rd, rs1, rs2, wb_rd;
  logic [31:0] mem_data, alu_data, wb_data, rs1_data, rs2_data;
  logic        in_ready, wb_en, rs1_hit, rs2_hit, overflow;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  regfile_wb_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .in_ready(in_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mv; logic [4:0] mrd; logic [31:0] md;
    logic        av; logic [4:0] ard; logic [31:0] ad;
    logic [4:0]  r1, r2;
    logic [2:0]  cnt; logic wen; logic [4:0] wrd; logic [31:0] wd; logic rdy;
    logic        h1; logic [31:0] d1; logic h2; logic [31:0] d2; logic ovf;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic [2:0] cnt, input logic wen, input logic [4:0] wrd, input logic [31:0] wd,
    input logic rdy, input logic h1, input logic [31:0] d1,
    input logic h2, input logic [31:0] d2, input logic ovf);
    vec_t v;
    v.mv = mv; v.mrd = mrd; v.md = md; v.av = av; v.ard = ard; v.ad = ad;
    v.r1 = r1; v.r2 = r2; v.cnt = cnt; v.wen = wen; v.wrd = wrd; v.wd = wd;
    v.rdy = rdy; v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] r1, input logic [4:0] r2);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    rs1 = r1; rs2 = r2;
  endtask

  initial begin
    // inputs                                    rs       cnt en rd  data         rdy h1 d1           h2 d2           ovf
    vecs[0]  = mk(0,0,0,          1,5,32'h1234,  5,0,  1,0,0,32'h0,        1, 1,32'h1234,    0,0,          0);
    vecs[1]  = mk(0,0,0,          0,0,0,         5,0,  0,1,5,32'h1234,     1, 1,32'h1234,    0,0,          0);
    vecs[2]  = mk(0,0,0,          0,0,0,         5,0,  0,0,5,32'h1234,     1, 0,0,           0,0,          0);
    vecs[3]  = mk(1,3,32'hAAAA0000,1,4,32'hBBBB, 3,4,  2,0,5,32'h1234,     1, 1,32'hAAAA0000,1,32'hBBBB,   0);
    vecs[4]  = mk(0,0,0,          0,0,0,         3,4,  1,1,3,32'hAAAA0000, 1, 1,32'hAAAA0000,1,32'hBBBB,   0);
    vecs[5]  = mk(0,0,0,          0,0,0,         3,4,  0,1,4,32'hBBBB,     1, 0,0,           1,32'hBBBB,   0);
    vecs[6]  = mk(0,0,0,          0,0,0,         3,4,  0,0,4,32'hBBBB,     1, 0,0,           0,0,          0);
    vecs[7]  = mk(1,0,32'hDEAD,   1,0,32'hBEEF,  0,0,  0,0,4,32'hBBBB,     1, 0,0,           0,0,          0);
    vecs[8]  = mk(0,0,0,          1,7,32'h1,     7,0,  1,0,4,32'hBBBB,     1, 1,32'h1,       0,0,          0);
    vecs[9]  = mk(0,0,0,          1,7,32'h2,     7,0,  1,1,7,32'h1,        1, 1,32'h2,       0,0,          0);
    vecs[10] = mk(0,0,0,          0,0,0,         7,0,  0,1,7,32'h2,        1, 1,32'h2,       0,0,          0);
    vecs[11] = mk(0,0,0,          0,0,0,         7,0,  0,0,7,32'h2,        1, 0,0,           0,0,          0);
    vecs[12] = mk(1,1,32'h11,     1,2,32'h22,    2,1,  2,0,7,32'h2,        1, 1,32'h22,      1,32'h11,     0);
    vecs[13] = mk(1,3,32'h33,     1,6,32'h66,    6,1,  3,1,1,32'h11,       0, 1,32'h66,      1,32'h11,     0);
    vecs[14] = mk(1,8,32'h88,     1,9,32'h99,    8,2,  2,1,2,32'h22,       1, 0,0,           1,32'h22,     1);
    vecs[15] = mk(0,0,0,          0,0,0,         3,6,  1,1,3,32'h33,       1, 1,32'h33,      1,32'h66,     1);
    vecs[16] = mk(0,0,0,          0,0,0,         9,6,  0,1,6,32'h66,       1, 0,0,           1,32'h66,     1);
    vecs[17] = mk(0,0,0,          0,0,0,         6,0,  0,0,6,32'h66,       1, 0,0,           0,0,          1);

    rst = 1'b1;
    drive(0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rs_hit", 32'({rs1_hit, rs2_hit}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].mv, vecs[i].mrd, vecs[i].md, vecs[i].av, vecs[i].ard, vecs[i].ad,
            vecs[i].r1, vecs[i].r2);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i),    32'(count),    32'(vecs[i].cnt));
      check($sformatf("v%0d_wb_en", i),    32'(wb_en),    32'(vecs[i].wen));
      check($sformatf("v%0d_wb_rd", i),    32'(wb_rd),    32'(vecs[i].wrd));
      check($sformatf("v%0d_wb_data", i),  wb_data,       vecs[i].wd);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d_rs1_hit", i),  32'(rs1_hit),  32'(vecs[i].h1));
      check($sformatf("v%0d_rs1_data", i), rs1_data,      vecs[i].d1);
      check($sformatf("v%0d_rs2_hit", i),  32'(rs2_hit),  32'(vecs[i].h2));
      check($sformatf("v%0d_rs2_data", i), rs2_data,      vecs[i].d2);
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
    end

    // Reset mid-operation: queued entries and a same-cycle push are discarded.
    @(negedge clk);
    drive(1,10,32'hA,1,11,32'hB,10,11);
    @(posedge clk);
    #1;
    check("mid_count", 32'(count), 32'd2);
    check("mid_rs1", rs1_data, 32'hA);
    @(negedge clk);
    rst = 1'b1;
    drive(0,0,0,1,12,32'hC,10,12);
    @(posedge clk);
    #1;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_wb_en", 32'(wb_en), 32'd0);
    check("mrst_wb_rd", 32'(wb_rd), 32'd0);
    check("mrst_overflow", 32'(overflow), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_hits", 32'({rs1_hit, rs2_hit}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0,0,0,0,0,0,10,11);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("post_rst_wb_en", 32'(wb_en), 32'd0);
      check("post_rst_count", 32'(count), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
